sdc_wb_slave_regs: RTL and testbench

SDC_WB_SLAVE_REGS -- requirements
Module: sdc_wb_slave_regs

---
 rtl/sdc_wb_slave_regs.sv | 255 +++++++++++++++++++++++++
 tb/tb_sdc_wb_slave_regs.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_wb_slave_regs.sv
// Wishbone register slave for an SD host controller: the register file plus a
// timed command engine that completes or times out after a COMMAND write.
module sdc_wb_slave_regs #(
  parameter int unsigned CMD_LATENCY = 16,
  parameter int unsigned VOLTAGE_MV  = 3300
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [7:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        cmd_busy_o,
  output logic        int_cmd_o
);

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned EVT_W  = 5;
  localparam int unsigned CMD_W  = 14;
  localparam int unsigned BSZ_W  = 12;
  localparam int unsigned BCNT_W = 16;
  localparam int unsigned DIV_W  = 8;

  localparam logic [CNT_W-1:0] LAT_M1         = CNT_W'(CMD_LATENCY - 1);
  localparam logic [BSZ_W-1:0] BLOCK_SIZE_RST = BSZ_W'(511);

  localparam logic [7:0] ADR_ARGUMENT      = 8'h00;
  localparam logic [7:0] ADR_COMMAND       = 8'h04;
  localparam logic [7:0] ADR_RESPONSE_0    = 8'h08;
  localparam logic [7:0] ADR_RESPONSE_1    = 8'h0C;
  localparam logic [7:0] ADR_RESPONSE_2    = 8'h10;
  localparam logic [7:0] ADR_RESPONSE_3    = 8'h14;
  localparam logic [7:0] ADR_DATA_TIMEOUT  = 8'h18;
  localparam logic [7:0] ADR_CONTROL       = 8'h1C;
  localparam logic [7:0] ADR_CMD_TIMEOUT   = 8'h20;
  localparam logic [7:0] ADR_CLOCK_DIV     = 8'h24;
  localparam logic [7:0] ADR_VOLTAGE       = 8'h2C;
  localparam logic [7:0] ADR_CMD_EVT_STAT  = 8'h34;
  localparam logic [7:0] ADR_CMD_EVT_EN    = 8'h38;
  localparam logic [7:0] ADR_DATA_EVT_EN   = 8'h40;
  localparam logic [7:0] ADR_BLOCK_SIZE    = 8'h44;
  localparam logic [7:0] ADR_BLOCK_COUNT   = 8'h48;
  localparam logic [7:0] ADR_DATA_XFER_ADR = 8'h60;

  typedef enum logic {IDLE, BUSY} cmd_state_e;

  cmd_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic               armed_q;
  logic               busy_q, busy_d;
  logic               int_q, int_d;

  logic [31:0]        argument_q, argument_d;
  logic [CMD_W-1:0]   command_q, command_d;
  logic [31:0]        resp0_q, resp0_d;
  logic [31:0]        resp1_q, resp1_d;
  logic [31:0]        resp2_q, resp2_d;
  logic [31:0]        resp3_q, resp3_d;
  logic [CNT_W-1:0]   data_timeout_q, data_timeout_d;
  logic               control_q, control_d;
  logic [CNT_W-1:0]   cmd_timeout_q, cmd_timeout_d;
  logic [DIV_W-1:0]   clock_div_q, clock_div_d;
  logic [EVT_W-1:0]   cmd_evt_stat_q, cmd_evt_stat_d;
  logic [EVT_W-1:0]   cmd_evt_en_q, cmd_evt_en_d;
  logic [EVT_W-1:0]   data_evt_en_q, data_evt_en_d;
  logic [BSZ_W-1:0]   block_size_q, block_size_d;
  logic [BCNT_W-1:0]  block_count_q, block_count_d;
  logic [31:0]        data_xfer_adr_q, data_xfer_adr_d;

  logic               req_c;
  logic               wr_c;
  logic [31:0]        wmask_c;
  logic [31:0]        rd_c;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // armed_q holds off the very first edge after reset release
  assign req_c   = wb_cyc_i & wb_stb_i & ~ack_q & armed_q;
  assign wr_c    = req_c & wb_we_i;
  assign wmask_c = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

  // read mux; unmapped and read-as-zero locations fall through to 0
  always_comb begin
    rd_c = '0;
    case (wb_adr_i)
      ADR_ARGUMENT:      rd_c = argument_q;
      ADR_COMMAND:       rd_c = 32'(command_q);
      ADR_RESPONSE_0:    rd_c = resp0_q;
      ADR_RESPONSE_1:    rd_c = resp1_q;
      ADR_RESPONSE_2:    rd_c = resp2_q;
      ADR_RESPONSE_3:    rd_c = resp3_q;
      ADR_DATA_TIMEOUT:  rd_c = 32'(data_timeout_q);
      ADR_CONTROL:       rd_c = 32'(control_q);
      ADR_CMD_TIMEOUT:   rd_c = 32'(cmd_timeout_q);
      ADR_CLOCK_DIV:     rd_c = 32'(clock_div_q);
      ADR_VOLTAGE:       rd_c = 32'(VOLTAGE_MV);
      ADR_CMD_EVT_STAT:  rd_c = 32'(cmd_evt_stat_q);
      ADR_CMD_EVT_EN:    rd_c = 32'(cmd_evt_en_q);
      ADR_DATA_EVT_EN:   rd_c = 32'(data_evt_en_q);
      ADR_BLOCK_SIZE:    rd_c = 32'(block_size_q);
      ADR_BLOCK_COUNT:   rd_c = 32'(block_count_q);
      ADR_DATA_XFER_ADR: rd_c = data_xfer_adr_q;
      default:           rd_c = '0;
    endcase
  end

  // register writes, then the command engine; engine completion is applied last
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    argument_d      = argument_q;
    command_d       = command_q;
    resp0_d         = resp0_q;
    resp1_d         = resp1_q;
    resp2_d         = resp2_q;
    resp3_d         = resp3_q;
    data_timeout_d  = data_timeout_q;
    control_d       = control_q;
    cmd_timeout_d   = cmd_timeout_q;
    clock_div_d     = clock_div_q;
    cmd_evt_stat_d  = cmd_evt_stat_q;
    cmd_evt_en_d    = cmd_evt_en_q;
    data_evt_en_d   = data_evt_en_q;
    block_size_d    = block_size_q;
    block_count_d   = block_count_q;
    data_xfer_adr_d = data_xfer_adr_q;

    if (wr_c) begin
      case (wb_adr_i)
        ADR_ARGUMENT:      argument_d = lane_merge(argument_q, wb_dat_i, wmask_c);
        ADR_COMMAND: begin
          if (state_q == IDLE) begin
            command_d = CMD_W'(lane_merge(32'(command_q), wb_dat_i, wmask_c));
          end
        end
        ADR_DATA_TIMEOUT:  data_timeout_d  = CNT_W'(lane_merge(32'(data_timeout_q), wb_dat_i, wmask_c));
        ADR_CONTROL:       control_d       = 1'(lane_merge(32'(control_q), wb_dat_i, wmask_c));
        ADR_CMD_TIMEOUT:   cmd_timeout_d   = CNT_W'(lane_merge(32'(cmd_timeout_q), wb_dat_i, wmask_c));
        ADR_CLOCK_DIV:     clock_div_d     = DIV_W'(lane_merge(32'(clock_div_q), wb_dat_i, wmask_c));
        ADR_CMD_EVT_STAT:  cmd_evt_stat_d  = '0;
        ADR_CMD_EVT_EN:    cmd_evt_en_d    = EVT_W'(lane_merge(32'(cmd_evt_en_q), wb_dat_i, wmask_c));
        ADR_DATA_EVT_EN:   data_evt_en_d   = EVT_W'(lane_merge(32'(data_evt_en_q), wb_dat_i, wmask_c));
        ADR_BLOCK_SIZE:    block_size_d    = BSZ_W'(lane_merge(32'(block_size_q), wb_dat_i, wmask_c));
        ADR_BLOCK_COUNT:   block_count_d   = BCNT_W'(lane_merge(32'(block_count_q), wb_dat_i, wmask_c));
        ADR_DATA_XFER_ADR: data_xfer_adr_d = lane_merge(data_xfer_adr_q, wb_dat_i, wmask_c);
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (wr_c && (wb_adr_i == ADR_COMMAND)) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (cnt_q == cmd_timeout_q) begin
          cmd_evt_stat_d = cmd_evt_stat_d | EVT_W'(5'b00011);
          state_d        = IDLE;
          cnt_d          = '0;
        end else if (cnt_q == LAT_M1) begin
          cmd_evt_stat_d = cmd_evt_stat_d | EVT_W'(5'b00001);
          if (command_q[1:0] != 2'b00) begin
            resp0_d = argument_q;
          end
          resp1_d = '0;
          resp2_d = '0;
          resp3_d = '0;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // bus response and registered status outputs
  always_comb begin
    ack_d  = req_c;
    dat_d  = req_c ? rd_c : '0;
    busy_d = (state_d == BUSY);
    int_d  = |(cmd_evt_stat_d & cmd_evt_en_d);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      ack_q           <= 1'b0;
      dat_q           <= '0;
      armed_q         <= 1'b0;
      busy_q          <= 1'b0;
      int_q           <= 1'b0;
      argument_q      <= '0;
      command_q       <= '0;
      resp0_q         <= '0;
      resp1_q         <= '0;
      resp2_q         <= '0;
      resp3_q         <= '0;
      data_timeout_q  <= '0;
      control_q       <= 1'b0;
      cmd_timeout_q   <= '0;
      clock_div_q     <= '0;
      cmd_evt_stat_q  <= '0;
      cmd_evt_en_q    <= '0;
      data_evt_en_q   <= '0;
      block_size_q    <= BLOCK_SIZE_RST;
      block_count_q   <= '0;
      data_xfer_adr_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ack_q           <= ack_d;
      dat_q           <= dat_d;
      armed_q         <= 1'b1;
      busy_q          <= busy_d;
      int_q           <= int_d;
      argument_q      <= argument_d;
      command_q       <= command_d;
      resp0_q         <= resp0_d;
      resp1_q         <= resp1_d;
      resp2_q         <= resp2_d;
      resp3_q         <= resp3_d;
      data_timeout_q  <= data_timeout_d;
      control_q       <= control_d;
      cmd_timeout_q   <= cmd_timeout_d;
      clock_div_q     <= clock_div_d;
      cmd_evt_stat_q  <= cmd_evt_stat_d;
      cmd_evt_en_q    <= cmd_evt_en_d;
      data_evt_en_q   <= data_evt_en_d;
      block_size_q    <= block_size_d;
      block_count_q   <= block_count_d;
      data_xfer_adr_q <= data_xfer_adr_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign cmd_busy_o = busy_q;
  assign int_cmd_o  = int_q;

endmodule

// File: tb/tb_sdc_wb_slave_regs.sv
// Bench for sdc_wb_slave_regs: transaction-level register/command model feeding
// an expected-read queue that a negedge monitor drains on every ack.
module tb_sdc_wb_slave_regs;

  localparam int unsigned LAT = 16;
  localparam int unsigned VMV = 3300;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  adr   = '0;
  logic [31:0] wdat  = '0;
  logic [3:0]  sel   = '0;
  logic        we    = 1'b0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic [31:0] rdat;
  logic        ack;
  logic        busy;
  logic        irq;

  sdc_wb_slave_regs #(.CMD_LATENCY(LAT), .VOLTAGE_MV(VMV)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_adr_i  (adr),
    .wb_dat_i  (wdat),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_dat_o  (rdat),
    .wb_ack_o  (ack),
    .cmd_busy_o(busy),
    .int_cmd_o (irq)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] expq [$];

  // model: one word per 32-bit slot (index = adr[6:2]); command lifetime as edge numbers
  logic [31:0] mreg [0:31];
  bit pending;
  bit tmo;
  int last_acc;
  int last_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [31:0] rw_mask(input logic [4:0] idx);
    case (idx)
      5'd0:  return 32'hFFFF_FFFF;
      5'd1:  return 32'h0000_3FFF;
      5'd6:  return 32'h00FF_FFFF;
      5'd7:  return 32'h0000_0001;
      5'd8:  return 32'h00FF_FFFF;
      5'd9:  return 32'h0000_00FF;
      5'd14: return 32'h0000_001F;
      5'd16: return 32'h0000_001F;
      5'd17: return 32'h0000_0FFF;
      5'd18: return 32'h0000_FFFF;
      5'd24: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [4:0] idx;
    idx = a[6:2];
    if (a[1:0] != 2'b00 || a[7]) return 32'h0;
    case (idx)
      5'd11: return 32'(VMV);
      5'd2, 5'd3, 5'd4, 5'd5, 5'd13: return mreg[idx];
      default: return mreg[idx] & rw_mask(idx);
    endcase
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit busy_now);
    logic [31:0] bm;
    logic [4:0]  idx;
    bm  = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    idx = a[6:2];
    if (a[1:0] == 2'b00 && !a[7]) begin
      if (idx == 5'd13) mreg[13] = 32'h0;
      else if (rw_mask(idx) != 32'h0 && !(idx == 5'd1 && busy_now))
        mreg[idx] = ((mreg[idx] & ~bm) | (d & bm)) & rw_mask(idx);
    end
  endtask

  task automatic complete(input logic [31:0] arg_snap);
    if (tmo) mreg[13] = mreg[13] | 32'h3;
    else begin
      mreg[13] = mreg[13] | 32'h1;
      if (mreg[1][1:0] != 2'b00) mreg[2] = arg_snap;
      mreg[3] = 32'h0;
      mreg[4] = 32'h0;
      mreg[5] = 32'h0;
    end
  endtask

  task automatic sync(input int e);
    if (pending && last_done < e) begin
      complete(mreg[0]);
      pending = 1'b0;
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    mreg[17]  = 32'd511;
    pending   = 1'b0;
    tmo       = 1'b0;
    last_acc  = 0;
    last_done = 0;
  endtask

  // one transfer, acked at edge e; model is updated with the effect of edge e
  task automatic xfer(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int          e;
    int unsigned cto;
    bit          busy_now;
    bit          fin;
    logic [31:0] snap;
    @(negedge clk);
    e = edge_n + 1;
    sync(e);
    expq.push_back(m_read(a));
    busy_now = pending && (last_acc < e) && (e <= last_done);
    fin      = pending && (last_done == e);
    snap     = mreg[0];
    if (w) m_write(a, d, s, busy_now);
    if (fin) begin
      complete(snap);
      pending = 1'b0;
    end
    if (w && a == 8'h04 && !busy_now) begin
      cto      = mreg[8];
      pending  = 1'b1;
      last_acc = e;
      if (cto <= LAT - 1) begin
        tmo       = 1'b1;
        last_done = e + int'(cto) + 1;
      end else begin
        tmo       = 1'b0;
        last_done = e + int'(LAT);
      end
    end
    we = w; adr = a; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ack_latency", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic check_irq(input string name);
    sync(edge_n + 1);
    chk(name, 32'(irq), 32'(|(mreg[13] & mreg[14])));
  endtask

  task automatic count_busy(input string name, input int exp_cycles);
    int n;
    n = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(n), 32'(exp_cycles));
  endtask

  // monitor: read data on every ack, zero data otherwise, busy against model lifetime
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        if (expq.size() == 0) chk("ack_no_request", 32'(expq.size()), 32'd1);
        else chk("rdata", rdat, expq.pop_front());
      end else begin
        chk("rdata_idle", rdat, 32'h0);
      end
      chk("cmd_busy", 32'(busy), 32'((last_acc <= edge_n) && (edge_n < last_done)));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (vectors %0d)", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] alist [24];
    logic [7:0] a;
    logic [31:0] d;
    int n_ack;
    int consec;
    bit prev;

    alist = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
              8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C,
              8'h40, 8'h44, 8'h48, 8'h60, 8'h50, 8'h4C, 8'h03, 8'hFC};

    reset_model();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_dat", rdat, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // reset values and basic readback
    xfer(1'b0, 8'h44, 32'h0, 4'hF);
    xfer(1'b0, 8'h2C, 32'h0, 4'hF);
    xfer(1'b0, 8'h04, 32'h0, 4'hF);
    xfer(1'b1, 8'h18, 32'h0000_7FFF, 4'hF);
    xfer(1'b0, 8'h18, 32'h0, 4'hF);
    xfer(1'b1, 8'h48, 32'hAABB_CCDD, 4'b0101);
    xfer(1'b0, 8'h48, 32'h0, 4'hF);
    xfer(1'b1, 8'h24, 32'hFFFF_FFFF, 4'hF);
    xfer(1'b0, 8'h24, 32'h0, 4'hF);

    // normal completion after CMD_LATENCY busy cycles
    xfer(1'b1, 8'h20, 32'h0000_7FFF, 4'hF);
    xfer(1'b1, 8'h00, 32'h1234_5678, 4'hF);
    xfer(1'b1, 8'h04, 32'h0000_0201, 4'hF);
    count_busy("busy_cycles_latency", int'(LAT));
    xfer(1'b0, 8'h34, 32'h0, 4'hF);
    xfer(1'b0, 8'h08, 32'h0, 4'hF);
    xfer(1'b0, 8'h0C, 32'h0, 4'hF);
    check_irq("irq_disabled");

    // timeout path and interrupt masking
    xfer(1'b1, 8'h20, 32'h3, 4'hF);
    xfer(1'b1, 8'h04, 32'h0000_0002, 4'hF);
    count_busy("busy_cycles_timeout", 4);
    xfer(1'b0, 8'h34, 32'h0, 4'hF);
    xfer(1'b1, 8'h38, 32'h2, 4'hF);
    check_irq("irq_enabled");
    chk("irq_enabled_high", 32'(irq), 32'd1);
    xfer(1'b1, 8'h34, 32'h0, 4'hF);
    check_irq("irq_cleared");
    chk("irq_cleared_low", 32'(irq), 32'd0);
    xfer(1'b1, 8'h20, 32'h0, 4'hF);
    xfer(1'b1, 8'h04, 32'h0000_0003, 4'hF);
    count_busy("busy_cycles_zero_timeout", 1);
    xfer(1'b0, 8'h34, 32'h0, 4'hF);

    // held strobe: ack every other cycle
    @(negedge clk);
    for (int i = 0; i < 3; i++) expq.push_back(32'(VMV));
    adr = 8'h2C; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    n_ack = 0; consec = 0; prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack) begin
        n_ack++;
        if (prev) consec++;
      end
      prev = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("held_ack_count", 32'(n_ack), 32'd3);
    chk("held_ack_consecutive", 32'(consec), 32'd0);

    // unmapped address
    xfer(1'b1, 8'h50, 32'hDEAD_BEEF, 4'hF);
    xfer(1'b0, 8'h50, 32'h0, 4'hF);

    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      a = alist[$urandom_range(0, 23)];
      d = $urandom();
      if (a == 8'h20) begin
        if (edge_n + 2 <= last_done) a = 8'h1C;
        else d = 32'($urandom_range(0, 30));
      end
      xfer(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      check_irq("irq_random");
    end

    // asynchronous reset during a busy command and a live ack
    repeat (40) @(negedge clk);
    xfer(1'b1, 8'h38, 32'h1, 4'hF);
    xfer(1'b1, 8'h20, 32'h0000_7FFF, 4'hF);
    xfer(1'b1, 8'h04, 32'h0000_0001, 4'hF);
    repeat (20) @(negedge clk);
    check_irq("irq_before_reset_model");
    chk("irq_before_reset", 32'(irq), 32'd1);
    xfer(1'b1, 8'h04, 32'h0000_0003, 4'hF);
    repeat (3) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'd1);
    @(negedge clk);
    adr = 8'h2C; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_before_reset", 32'(ack), 32'd1);
    rst_n = 1'b0;
    #1;
    reset_model();
    chk("async_reset_ack", 32'(ack), 32'h0);
    chk("async_reset_dat", rdat, 32'h0);
    chk("async_reset_busy", 32'(busy), 32'h0);
    chk("async_reset_irq", 32'(irq), 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    xfer(1'b0, 8'h04, 32'h0, 4'hF);
    xfer(1'b0, 8'h44, 32'h0, 4'hF);
    xfer(1'b0, 8'h38, 32'h0, 4'hF);
    xfer(1'b0, 8'h20, 32'h0, 4'hF);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
